param_register_file: RTL and testbench
======================================

// Module: param_register_file
// PURPOSE
//   Parametrised register file for the next-generation single-cycle/pipelined datapath.
//   Two combinational read ports, one clocked write port, optional hardwired-zero entry 0
//   and optional same-cycle write-to-read bypass.
//   Adds a per-register pending-write scoreboard for hazard detection.
//   Adds a sequential bulk-clear engine that zeroes one entry per cycle.
//   Sits between decode (read addresses, scoreboard set) and writeback (write port).
// PARAMETERS
//   WIDTH     32  data width of each register, in bits
//   DEPTH     32  number of registers (>=2; need not be a power of 2)
//   ZERO_REG0 1   1: entry 0 always reads 0, and writes and sb_set to it are ignored
//   BYPASS    1   1: an accepted write is forwarded to a read port in the same cycle
//   AW        $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   we         in   1      write enable
//   waddr      in   AW     write address
//   wdata      in   WIDTH  write data
//   raddr1     in   AW     read address, port 1 (rs)
//   raddr2     in   AW     read address, port 2 (rt)
//   rdata1     out  WIDTH  read data, port 1 (combinational)
//   rdata2     out  WIDTH  read data, port 2 (combinational)
//   sb_set     in   1      mark register sb_addr as pending (producer issued)
//   sb_addr    in   AW     scoreboard set address
//   rpend1     out  1      pending bit of raddr1 (combinational lookup)
//   rpend2     out  1      pending bit of raddr2 (combinational lookup)
//   clr_req    in   1      start bulk clear (sampled in IDLE only)
//   clr_busy   out  1      high while the clear engine runs
//   wr_drop    out  1      registered one-cycle pulse: a write was rejected during clear
// BEHAVIOUR
//   Reset (rst=1, asynchronous):
//     - All registers and pending bits go to 0; FSM goes to IDLE; clear counter goes to 0.
//     - clr_busy=0, wr_drop=0. Reads therefore return 0.
//     - Applies immediately, including in the middle of a clear.
//   Write:
//     - A write is accepted when we=1, state=IDLE, waddr<DEPTH, and not (ZERO_REG0 and waddr==0).
//     - An accepted write updates regs[waddr]<=wdata on the rising edge (1-cycle latency).
//     - The same edge clears pend[waddr].
//   Read (pure combinational; no clock involved):
//     - If ZERO_REG0 and raddr==0, or raddr>=DEPTH: rdata=0.
//     - Else if BYPASS, and a write is accepted this cycle, and waddr==raddr: rdata=wdata.
//     - Else: rdata=regs[raddr].
//     - Both ports are independent; both may hit the bypass together.
//   Scoreboard:
//     - sb_set=1 sets pend[sb_addr] on the edge.
//     - Ignored in CLEAR, for sb_addr>=DEPTH, and for entry 0 when ZERO_REG0.
//     - If the same edge has an accepted write to the same address, set wins and the bit stays 1.
//     - rpend reflects stored bits only; there is no bypass.
//     - rpend is 0 for entry 0 when ZERO_REG0, and for out-of-range addresses.
//   Clear FSM, two states:
//     - IDLE -> CLEAR when clr_req=1; cnt<=0.
//     - In CLEAR, each edge zeroes regs[cnt] and pend[cnt], then cnt<=cnt+1.
//     - At cnt==DEPTH-1, clear that entry and return to IDLE.
//     - Total CLEAR duration is exactly DEPTH cycles; clr_busy=1 for all of them.
//     - clr_req while in CLEAR is ignored; there is no restart.
//   During CLEAR:
//     - Writes and sb_set are ignored.
//     - Reads return the current stored values, so the file may be partially cleared; no bypass.
//     - we=1 during CLEAR makes wr_drop=1 on the next cycle; otherwise wr_drop=0.
//     - At the IDLE transition edge, a write is still rejected (state was CLEAR).
// TESTING
//   1. rst pulse mid-cycle -> all rdata=0, rpend=0 and clr_busy=0 at once, without waiting for a clk edge.
//   2. we=1, waddr=5, wdata=32'hDEADBEEF with raddr1=5 in the same cycle
//      -> rdata1=DEADBEEF (bypass); rdata1 is still DEADBEEF after the edge with we=0.
//   3. we=1, waddr=0, wdata=32'h1234 (ZERO_REG0=1) -> rdata1=0 for raddr1=0 both before and after the edge.
//   4. sb_set to 7 -> rpend1=1 next cycle.
//      Then the same edge has sb_set to 7 and a write to 7 -> rpend1 stays 1.
//      Then a write alone to 7 -> rpend1=0.
//   5. Fill regs 1..31 with nonzero values, then pulse clr_req -> clr_busy=1 for exactly 32 cycles.
//      A write attempted mid-clear is dropped with a wr_drop pulse the next cycle.
//      After the clear, every read returns 0.
//   6. Assert rst at cycle 10 of a clear -> clr_busy=0 immediately and the FSM is in IDLE.
//      The next write to 3 succeeds and reads back.

Source files
------------

// File: rtl/param_register_file.sv
// Parametrised register file with two combinational read ports and one
// clocked write port. It includes a per-register pending-write scoreboard and
// a sequential bulk-clear engine that zeroes one entry per cycle.

// One storage entry: data word plus its pending bit.
module prf_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_set,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pend
);
  logic [WIDTH-1:0] r_data;
  logic             r_pend;

  // Clear has top priority. A set beats a write to the same entry, so a freshly
  // issued producer is not hidden by an older writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_pend <= 1'b0;
    end else if (i_clr) begin
      r_data <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_wr)       r_data <= i_wdata;
      if (i_set)      r_pend <= 1'b1;
      else if (i_wr)  r_pend <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_pend = r_pend;
endmodule

module param_register_file #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  output logic             rpend1,
  output logic             rpend2,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             wr_drop
);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_clr_busy;
  logic          r_wr_drop;

  logic                        w_idle;
  logic                        w_wr_ok;
  logic                        w_set_ok;
  logic [DEPTH-1:0]            w_wr;
  logic [DEPTH-1:0]            w_set;
  logic [DEPTH-1:0]            w_clr;
  logic [DEPTH-1:0][WIDTH-1:0] w_regs;
  logic [DEPTH-1:0]            w_pend;

  assign w_idle = (r_state == S_IDLE);

  // An address is usable when it is inside the file and is not the hardwired zero entry.
  // Addresses are zero-extended to 32 bits, so the range test also works for
  // DEPTH values that are not a power of 2.
  assign w_wr_ok  = we && w_idle && (32'(waddr) < DEPTH_U) &&
                    !((ZERO_REG0 != 0) && (waddr == '0));
  assign w_set_ok = sb_set && w_idle && (32'(sb_addr) < DEPTH_U) &&
                    !((ZERO_REG0 != 0) && (sb_addr == '0));

  // Clear FSM: walks r_cnt from 0 to DEPTH-1, one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_wr_drop <= (r_state == S_CLEAR) && we;
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clr_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = r_clr_busy;
  assign wr_drop  = r_wr_drop;

  // Storage array. Entry 0 never receives a write or a set when it is hardwired,
  // because those cases are already excluded from w_wr_ok and w_set_ok.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_wr[g]  = w_wr_ok  && (waddr   == AW'(g));
    assign w_set[g] = w_set_ok && (sb_addr == AW'(g));
    assign w_clr[g] = (r_state == S_CLEAR) && (r_cnt == AW'(g));

    prf_entry #(.WIDTH(WIDTH)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[g]),
      .i_wdata (wdata),
      .i_set   (w_set[g]),
      .i_clr   (w_clr[g]),
      .o_data  (w_regs[g]),
      .o_pend  (w_pend[g])
    );
  end

  // Read ports. Both ports use the same logic and are fully independent.
  logic [1:0][AW-1:0]    w_raddr;
  logic [1:0][WIDTH-1:0] w_rdata;
  logic [1:0]            w_rpend;

  assign w_raddr = {raddr2, raddr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic             w_ok;
    logic [WIDTH-1:0] w_d;
    logic             w_p;

    assign w_ok = (32'(w_raddr[p]) < DEPTH_U) &&
                  !((ZERO_REG0 != 0) && (w_raddr[p] == '0));

    // Forward an accepted write in the same cycle. Pending bits have no forward path.
    always_comb begin
      w_d = '0;
      w_p = 1'b0;
      if (w_ok) begin
        if ((BYPASS != 0) && w_wr_ok && (waddr == w_raddr[p])) w_d = wdata;
        else                                                  w_d = w_regs[w_raddr[p]];
        w_p = w_pend[w_raddr[p]];
      end
    end

    assign w_rdata[p] = w_d;
    assign w_rpend[p] = w_p;
  end

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];
  assign rpend1 = w_rpend[0];
  assign rpend2 = w_rpend[1];
endmodule

// File: tb/tb_param_register_file.sv
// Randomised scoreboard bench for param_register_file (WIDTH=32, DEPTH=32,
// ZERO_REG0=1, BYPASS=1). The driver pushes the expected outputs for each
// cycle into a queue. The monitor pops the queue and compares at the falling edge.
module tb_param_register_file;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0, sb_set = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] waddr = '0, raddr1 = '0, raddr2 = '0, sb_addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata1, rdata2;
  logic          rpend1, rpend2, clr_busy, wr_drop;

  always #5 clk = ~clk;

  param_register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG0(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .sb_set(sb_set), .sb_addr(sb_addr), .rpend1(rpend1), .rpend2(rpend2),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  typedef struct packed {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         p1, p2, busy, drop;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic chk_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain arrays, a count of clear cycles still to run, and the next index to clear.
  logic [W-1:0] m_mem  [D];
  bit           m_pend [D];
  int           clr_left, clr_idx;
  bit           m_drop;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (clr_left == 0 && we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit m_rp(input logic [AW-1:0] a);
    return (a == 0) ? 1'b0 : m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    clr_left = 0; clr_idx = 0; m_drop = 1'b0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      m_mem[clr_idx] = '0; m_pend[clr_idx] = 1'b0;
      clr_idx++; clr_left--;
      m_drop = we;
    end else begin
      m_drop = 1'b0;
      if (we && waddr != 0) begin m_mem[waddr] = wdata; m_pend[waddr] = 1'b0; end
      if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
      if (clr_req) begin clr_left = D; clr_idx = 0; end
    end
  endtask

  // One clock cycle with the inputs that are currently driven.
  task automatic cycle();
    exp_t e;
    e.r1 = m_read(raddr1); e.r2 = m_read(raddr2);
    e.p1 = m_rp(raddr1);   e.p2 = m_rp(raddr2);
    e.busy = (clr_left > 0); e.drop = m_drop;
    q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    model_edge();
    #1 chk_vld = 1'b0;
  endtask

  task automatic quiet();
    we = 1'b0; sb_set = 1'b0; clr_req = 1'b0;
  endtask

  task automatic rand_in(input int we_pct, input int sb_pct, input int clr_pct);
    we      = ($urandom_range(0, 99) < we_pct);
    waddr   = AW'($urandom_range(0, D-1));
    wdata   = $urandom;
    raddr1  = AW'($urandom_range(0, D-1));
    raddr2  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D-1));
    sb_set  = ($urandom_range(0, 99) < sb_pct);
    sb_addr = AW'($urandom_range(0, D-1));
    clr_req = ($urandom_range(0, 99) < clr_pct);
  endtask

  // Reset asserted mid-cycle must act at once, without waiting for a clock edge.
  task automatic mid_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rdata1", rdata1, '0);
    chk("rst_rdata2", rdata2, '0);
    chk("rst_rpend1", W'(rpend1), '0);
    chk("rst_rpend2", W'(rpend2), '0);
    chk("rst_busy", W'(clr_busy), '0);
    chk("rst_drop", W'(wr_drop), '0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic fill();
    for (int a = 1; a < D; a++) begin
      we = 1'b1; waddr = AW'(a); wdata = $urandom | 32'h1;
      raddr1 = AW'(a); raddr2 = AW'(a - 1);
      sb_set = 1'b0; clr_req = 1'b0;
      cycle();
    end
    quiet();
  endtask

  // Monitor: pops the expected entry for each cycle and compares it.
  always @(negedge clk) begin
    if (chk_vld) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got=0 expected=1 at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("rdata1", rdata1, mon_e.r1);
        chk("rdata2", rdata2, mon_e.r2);
        chk("rpend1", W'(rpend1), W'(mon_e.p1));
        chk("rpend2", W'(rpend2), W'(mon_e.p2));
        chk("clr_busy", W'(clr_busy), W'(mon_e.busy));
        chk("wr_drop", W'(wr_drop), W'(mon_e.drop));
      end
    end
  end

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state seen through the scoreboard
    raddr1 = 5'd3; raddr2 = 5'd17; cycle();

    // Same-cycle bypass, then read the stored value
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; cycle();
    we = 1'b0; cycle();

    // Writes to entry 0 are ignored and entry 0 always reads 0
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd0; raddr2 = 5'd0; cycle();
    we = 1'b0; cycle();

    // Scoreboard: set first, then set together with a write (set wins), then a write alone (clears)
    raddr1 = 5'd7; sb_set = 1'b1; sb_addr = 5'd7; cycle();
    sb_set = 1'b0; cycle();
    sb_set = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h77; cycle();
    sb_set = 1'b0; we = 1'b0; cycle();
    we = 1'b1; wdata = 32'h78; cycle();
    we = 1'b0; cycle();
    sb_set = 1'b1; sb_addr = 5'd0; raddr1 = 5'd0; cycle();
    quiet(); cycle();

    // Fill, then bulk clear with stray writes, sets and clear requests during the clear
    fill();
    sb_set = 1'b1; sb_addr = 5'd9; clr_req = 1'b1; raddr1 = 5'd9; cycle();
    n = 0;
    while (clr_busy && n < 60) begin
      rand_in(30, 30, 20);
      if (n == 10) we = 1'b1;
      if (n == D - 1) we = 1'b1;
      n++;
      cycle();
    end
    quiet();
    chk("clr_len", W'(n), W'(D));
    for (int a = 0; a < D; a += 2) begin
      raddr1 = AW'(a); raddr2 = AW'(a + 1); cycle();
    end

    // Reset at cycle 10 of a clear, then a normal write must work
    fill();
    sb_set = 1'b1; sb_addr = 5'd20; cycle();
    sb_set = 1'b0; clr_req = 1'b1; cycle();
    clr_req = 1'b0; raddr1 = 5'd25; raddr2 = 5'd20;
    repeat (9) cycle();
    mid_reset();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_0003; raddr1 = 5'd3; cycle();
    we = 1'b0; cycle();

    // Random traffic with occasional clears and one reset
    for (int i = 0; i < 600; i++) begin
      rand_in(60, 30, 2);
      cycle();
      if (i == 300) begin quiet(); mid_reset(); end
    end
    quiet(); cycle();

    @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
